// File: rtl/pipe_link_channel.sv
// PIPE-level link model between two endpoints: two independent fixed-latency pipelines,
// a training interval before the link comes up, and on-demand single-bit corruption.
module pipe_link_channel #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int LATENCY         = 4,
  parameter int TRAIN_CYCLES    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PIPE_DATA_WIDTH-1:0]         a_txdata_i,
  input  logic                               a_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         b_rxdata_o,
  output logic                               b_rxvalid_o,
  input  logic [PIPE_DATA_WIDTH-1:0]         b_txdata_i,
  input  logic                               b_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         a_rxdata_o,
  output logic                               a_rxvalid_o,
  input  logic                               err_inj_i,
  input  logic                               err_dir_i,
  input  logic [$clog2(PIPE_DATA_WIDTH)-1:0] err_bit_i,
  output logic                               link_up_o,
  output logic [31:0]                        ab_fwd_cnt_o,
  output logic [31:0]                        ba_fwd_cnt_o,
  output logic [15:0]                        ab_drop_cnt_o,
  output logic [15:0]                        ba_drop_cnt_o,
  output logic [15:0]                        ab_err_cnt_o,
  output logic [15:0]                        ba_err_cnt_o
);
  localparam int IDX_W = $clog2(PIPE_DATA_WIDTH);

  typedef enum logic [0:0] {ST_TRAIN = 1'b0, ST_UP = 1'b1} link_state_e;

  function automatic logic [PIPE_DATA_WIDTH-1:0] flip_mask(input logic en, input logic [IDX_W-1:0] idx);
    logic [PIPE_DATA_WIDTH-1:0] one;
    one = {{(PIPE_DATA_WIDTH-1){1'b0}}, 1'b1};
    return en ? (one << idx) : {PIPE_DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  link_state_e state_q, state_d;
  logic [9:0]  train_cnt_q, train_cnt_d;
  logic        link_up_q, link_up_d;

  // Index 0 is the A->B direction, index 1 is B->A.
  logic [PIPE_DATA_WIDTH-1:0] tx_data_s [2];
  logic                       tx_valid_s [2];
  logic                       admit_s [2];
  logic                       arm_s [2];
  logic [IDX_W-1:0]           idx_s [2];
  logic                       armed_q [2], armed_d [2];
  logic [IDX_W-1:0]           idx_q [2], idx_d [2];
  logic [31:0]                fwd_cnt_q [2], fwd_cnt_d [2];
  logic [15:0]                drop_cnt_q [2], drop_cnt_d [2];
  logic [15:0]                err_cnt_q [2], err_cnt_d [2];
  logic [PIPE_DATA_WIDTH-1:0] pipe_data_q [2][LATENCY], pipe_data_d [2][LATENCY];
  logic                       pipe_valid_q [2][LATENCY], pipe_valid_d [2][LATENCY];

  assign tx_data_s[0]  = a_txdata_i;
  assign tx_data_s[1]  = b_txdata_i;
  assign tx_valid_s[0] = a_txvalid_i;
  assign tx_valid_s[1] = b_txvalid_i;

  // Training FSM: UP is entered on the edge where the counter sits at TRAIN_CYCLES-1.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    case (state_q)
      ST_TRAIN: begin
        if (train_cnt_q == 10'(TRAIN_CYCLES - 1)) begin
          state_d = ST_UP;
        end else begin
          train_cnt_d = train_cnt_q + 10'd1;
        end
      end
      ST_UP:   state_d = ST_UP;
      default: state_d = ST_TRAIN;
    endcase
    link_up_d = (state_d == ST_UP);
  end

  // Per-direction admission, bit-flip arming and pipeline advance.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      admit_s[d]    = tx_valid_s[d] & link_up_q;
      // A pulse only arms an idle direction; an armed one keeps its earlier index.
      arm_s[d]      = armed_q[d] | (err_inj_i & (err_dir_i == 1'(d)));
      idx_s[d]      = armed_q[d] ? idx_q[d] : err_bit_i;
      armed_d[d]    = arm_s[d];
      idx_d[d]      = idx_s[d];
      fwd_cnt_d[d]  = fwd_cnt_q[d];
      drop_cnt_d[d] = drop_cnt_q[d];
      err_cnt_d[d]  = err_cnt_q[d];
      pipe_valid_d[d][0] = admit_s[d];
      pipe_data_d[d][0]  = {PIPE_DATA_WIDTH{1'b0}};
      if (admit_s[d]) begin
        pipe_data_d[d][0] = tx_data_s[d] ^ flip_mask(arm_s[d], idx_s[d]);
        fwd_cnt_d[d]      = sat_inc32(fwd_cnt_q[d]);
        if (arm_s[d]) begin
          armed_d[d]   = 1'b0;
          err_cnt_d[d] = sat_inc16(err_cnt_q[d]);
        end else begin
          err_cnt_d[d] = err_cnt_q[d];
        end
      end else if (tx_valid_s[d]) begin
        drop_cnt_d[d] = sat_inc16(drop_cnt_q[d]);
      end else begin
        drop_cnt_d[d] = drop_cnt_q[d];
      end
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid_d[d][s] = pipe_valid_q[d][s-1];
        pipe_data_d[d][s]  = pipe_data_q[d][s-1];
      end
    end
  end

  // State register; reset flushes both pipelines and clears arming and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_TRAIN;
      train_cnt_q <= 10'd0;
      link_up_q   <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        armed_q[d]    <= 1'b0;
        idx_q[d]      <= {IDX_W{1'b0}};
        fwd_cnt_q[d]  <= 32'd0;
        drop_cnt_q[d] <= 16'd0;
        err_cnt_q[d]  <= 16'd0;
        for (int s = 0; s < LATENCY; s++) begin
          pipe_valid_q[d][s] <= 1'b0;
          pipe_data_q[d][s]  <= {PIPE_DATA_WIDTH{1'b0}};
        end
      end
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      link_up_q   <= link_up_d;
      for (int d = 0; d < 2; d++) begin
        armed_q[d]    <= armed_d[d];
        idx_q[d]      <= idx_d[d];
        fwd_cnt_q[d]  <= fwd_cnt_d[d];
        drop_cnt_q[d] <= drop_cnt_d[d];
        err_cnt_q[d]  <= err_cnt_d[d];
        for (int s = 0; s < LATENCY; s++) begin
          pipe_valid_q[d][s] <= pipe_valid_d[d][s];
          pipe_data_q[d][s]  <= pipe_data_d[d][s];
        end
      end
    end
  end

  assign link_up_o     = link_up_q;
  assign b_rxvalid_o   = pipe_valid_q[0][LATENCY-1];
  assign b_rxdata_o    = pipe_data_q[0][LATENCY-1];
  assign a_rxvalid_o   = pipe_valid_q[1][LATENCY-1];
  assign a_rxdata_o    = pipe_data_q[1][LATENCY-1];
  assign ab_fwd_cnt_o  = fwd_cnt_q[0];
  assign ba_fwd_cnt_o  = fwd_cnt_q[1];
  assign ab_drop_cnt_o = drop_cnt_q[0];
  assign ba_drop_cnt_o = drop_cnt_q[1];
  assign ab_err_cnt_o  = err_cnt_q[0];
  assign ba_err_cnt_o  = err_cnt_q[1];

endmodule

// File: tb/tb_pipe_link_channel.sv
// Bench for pipe_link_channel: a queue-based delivery model checked every cycle,
// plus table-driven single-beat vectors and hand-written training/reset sequences.
module tb_pipe_link_channel;
  localparam int W  = 256;
  localparam int L  = 4;
  localparam int T  = 64;
  localparam int IW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] a_txdata_i = '0, b_txdata_i = '0, a_rxdata_o, b_rxdata_o;
  logic a_txvalid_i = 1'b0, b_txvalid_i = 1'b0, a_rxvalid_o, b_rxvalid_o;
  logic err_inj_i = 1'b0, err_dir_i = 1'b0;
  logic [IW-1:0] err_bit_i = '0;
  logic link_up_o;
  logic [31:0] ab_fwd_cnt_o, ba_fwd_cnt_o;
  logic [15:0] ab_drop_cnt_o, ba_drop_cnt_o, ab_err_cnt_o, ba_err_cnt_o;

  always #5 clk = ~clk;

  pipe_link_channel #(.PIPE_DATA_WIDTH(W), .LATENCY(L), .TRAIN_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .a_txdata_i(a_txdata_i), .a_txvalid_i(a_txvalid_i),
    .b_rxdata_o(b_rxdata_o), .b_rxvalid_o(b_rxvalid_o),
    .b_txdata_i(b_txdata_i), .b_txvalid_i(b_txvalid_i),
    .a_rxdata_o(a_rxdata_o), .a_rxvalid_o(a_rxvalid_o),
    .err_inj_i(err_inj_i), .err_dir_i(err_dir_i), .err_bit_i(err_bit_i),
    .link_up_o(link_up_o),
    .ab_fwd_cnt_o(ab_fwd_cnt_o), .ba_fwd_cnt_o(ba_fwd_cnt_o),
    .ab_drop_cnt_o(ab_drop_cnt_o), .ba_drop_cnt_o(ba_drop_cnt_o),
    .ab_err_cnt_o(ab_err_cnt_o), .ba_err_cnt_o(ba_err_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: edges since reset release, pending flip index, queued deliveries.
  typedef struct {
    int           at;
    logic [W-1:0] data;
  } beat_t;

  beat_t q_ab[$];
  beat_t q_ba[$];
  int    e = 0;
  int    pend [2] = '{-1, -1};
  longint fwd [2] = '{0, 0};
  int    drop [2] = '{0, 0};
  int    errc [2] = '{0, 0};

  task automatic model_dir(input int d, input logic v, input logic [W-1:0] dat);
    beat_t bt;
    if (err_inj_i && (int'(err_dir_i) == d) && pend[d] < 0) pend[d] = int'(err_bit_i);
    if (v) begin
      if (e >= T) begin
        bt.data = dat;
        if (pend[d] >= 0) begin
          bt.data[pend[d]] = ~bt.data[pend[d]];
          pend[d] = -1;
          if (errc[d] < 65535) errc[d]++;
        end
        if (fwd[d] < 64'hFFFF_FFFF) fwd[d]++;
        bt.at = e + L - 1;
        if (d == 0) q_ab.push_back(bt);
        else q_ba.push_back(bt);
      end else if (drop[d] < 65535) begin
        drop[d]++;
      end
    end
  endtask

  task automatic compare_all();
    int k;
    logic ev_b, ev_a;
    logic [W-1:0] ed_b, ed_a;
    k = e - 1;
    ev_b = 1'b0; ed_b = '0; ev_a = 1'b0; ed_a = '0;
    if (q_ab.size() > 0 && q_ab[0].at == k) begin ev_b = 1'b1; ed_b = q_ab[0].data; void'(q_ab.pop_front()); end
    if (q_ba.size() > 0 && q_ba[0].at == k) begin ev_a = 1'b1; ed_a = q_ba[0].data; void'(q_ba.pop_front()); end
    check("link_up", W'(link_up_o), W'(e >= T));
    check("b_rxvalid", W'(b_rxvalid_o), W'(ev_b));
    check("b_rxdata", b_rxdata_o, ed_b);
    check("a_rxvalid", W'(a_rxvalid_o), W'(ev_a));
    check("a_rxdata", a_rxdata_o, ed_a);
    check("ab_fwd", W'(ab_fwd_cnt_o), W'(fwd[0]));
    check("ba_fwd", W'(ba_fwd_cnt_o), W'(fwd[1]));
    check("ab_drop", W'(ab_drop_cnt_o), W'(drop[0]));
    check("ba_drop", W'(ba_drop_cnt_o), W'(drop[1]));
    check("ab_err", W'(ab_err_cnt_o), W'(errc[0]));
    check("ba_err", W'(ba_err_cnt_o), W'(errc[1]));
  endtask

  // One clock: advance the model with the current inputs, then sample on the falling edge.
  task automatic tick();
    if (rst) begin
      q_ab.delete(); q_ba.delete();
      e = 0;
      for (int d = 0; d < 2; d++) begin
        pend[d] = -1; fwd[d] = 0; drop[d] = 0; errc[d] = 0;
      end
    end else begin
      model_dir(0, a_txvalid_i, a_txdata_i);
      model_dir(1, b_txvalid_i, b_txdata_i);
      e++;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    a_txvalid_i = 1'b0; a_txdata_i = '0;
    b_txvalid_i = 1'b0; b_txdata_i = '0;
    err_inj_i = 1'b0; err_dir_i = 1'b0; err_bit_i = '0;
  endtask

  typedef struct {
    logic          av;
    logic [W-1:0]  ad;
    logic          bv;
    logic [W-1:0]  bd;
    logic          inj;
    logic          dir;
    logic [IW-1:0] bitn;
    logic          ebv;
    logic [W-1:0]  ebd;
    logic          eav;
    logic [W-1:0]  ead;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{1'b1, W'(8'hA5), 1'b1, W'(8'h5A), 1'b0, 1'b0, IW'(0), 1'b1, W'(8'hA5), 1'b1, W'(8'h5A)};
    vt[1] = '{1'b0, W'(0),     1'b0, W'(0),     1'b1, 1'b0, IW'(7), 1'b0, W'(0),     1'b0, W'(0)};
    vt[2] = '{1'b1, W'(0),     1'b0, W'(0),     1'b0, 1'b0, IW'(0), 1'b1, W'(8'h80), 1'b0, W'(0)};
    vt[3] = '{1'b1, W'(0),     1'b0, W'(0),     1'b0, 1'b0, IW'(0), 1'b1, W'(0),     1'b0, W'(0)};
    vt[4] = '{1'b0, W'(0),     1'b1, W'(1),     1'b1, 1'b1, IW'(0), 1'b0, W'(0),     1'b1, W'(0)};
    vt[5] = '{1'b0, W'(0),     1'b0, W'(0),     1'b1, 1'b0, IW'(3), 1'b0, W'(0),     1'b0, W'(0)};
    vt[6] = '{1'b1, W'(0),     1'b0, W'(0),     1'b1, 1'b0, IW'(9), 1'b1, W'(8'h08), 1'b0, W'(0)};
    vt[7] = '{1'b1, W'(0),     1'b0, W'(0),     1'b0, 1'b0, IW'(0), 1'b1, W'(0),     1'b0, W'(0)};

    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Training with A transmitting constantly: every beat before link-up is dropped.
    a_txvalid_i = 1'b1;
    for (int n = 1; n <= T; n++) begin
      a_txdata_i = {8{$urandom()}};
      tick();
      if (n == T - 1) check("train_link_low", W'(link_up_o), W'(0));
    end
    check("train_link_high", W'(link_up_o), W'(1));
    check("train_drop", W'(ab_drop_cnt_o), W'(T));
    idle_inputs();
    repeat (L + 1) tick();

    // Ten back-to-back beats keep order and spacing.
    for (int t = 0; t < 10 + L; t++) begin
      a_txvalid_i = (t < 10);
      a_txdata_i  = (t < 10) ? W'(t) : '0;
      tick();
      if (t >= L - 1 && t - (L - 1) < 10) begin
        check("order_valid", W'(b_rxvalid_o), W'(1));
        check("order_data", b_rxdata_o, W'(t - (L - 1)));
      end
    end
    check("order_fwd", W'(ab_fwd_cnt_o), W'(10));
    idle_inputs();

    // Reset while three beats are in flight.
    a_txvalid_i = 1'b1;
    for (int t = 0; t < 3; t++) begin a_txdata_i = W'(t + 100); tick(); end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < L + 2; t++) begin
      tick();
      check("flush_b_valid", W'(b_rxvalid_o), W'(0));
    end
    check("flush_fwd", W'(ab_fwd_cnt_o), W'(0));
    check("flush_drop", W'(ab_drop_cnt_o), W'(0));
    check("flush_link", W'(link_up_o), W'(0));
    repeat (T - (L + 2) - 1) tick();
    check("retrain_link_low", W'(link_up_o), W'(0));
    tick();
    check("retrain_link_high", W'(link_up_o), W'(1));

    // Single-beat vectors: bidirectional, injection, same-cycle injection, armed re-pulse.
    for (int i = 0; i < 8; i++) begin
      a_txvalid_i = vt[i].av;  a_txdata_i = vt[i].ad;
      b_txvalid_i = vt[i].bv;  b_txdata_i = vt[i].bd;
      err_inj_i   = vt[i].inj; err_dir_i  = vt[i].dir; err_bit_i = vt[i].bitn;
      tick();
      idle_inputs();
      repeat (L - 1) tick();
      check($sformatf("vec%0d_b_valid", i), W'(b_rxvalid_o), W'(vt[i].ebv));
      check($sformatf("vec%0d_b_data", i), b_rxdata_o, vt[i].ebd);
      check($sformatf("vec%0d_a_valid", i), W'(a_rxvalid_o), W'(vt[i].eav));
      check($sformatf("vec%0d_a_data", i), a_rxdata_o, vt[i].ead);
      if (i == 0) begin
        check("bidir_ab_fwd", W'(ab_fwd_cnt_o), W'(1));
        check("bidir_ba_fwd", W'(ba_fwd_cnt_o), W'(1));
      end
      tick();
    end
    check("inj_ab_err", W'(ab_err_cnt_o), W'(2));
    check("inj_ba_err", W'(ba_err_cnt_o), W'(1));

    // Random traffic and injections against the model, with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      rst         = (n == 200);
      a_txvalid_i = ($urandom_range(0, 3) != 0);
      a_txdata_i  = {8{$urandom()}};
      b_txvalid_i = ($urandom_range(0, 3) != 0);
      b_txdata_i  = {8{$urandom()}};
      err_inj_i   = ($urandom_range(0, 7) == 0);
      err_dir_i   = 1'($urandom_range(0, 1));
      err_bit_i   = IW'($urandom_range(0, W - 1));
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (L + 1) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_link_channel.md
# pipe_link_channel

Cycle-accurate PIPE-level link model between the PIPE ports of two PCIe endpoints. The block is a pair of independent pipelines, A→B and B→A, and sits directly downstream of each endpoint's DLL PIPE transmit port. It adds a fixed link latency, holds traffic off until a link-training interval has elapsed, and can flip single bits on demand so that LCRC/replay paths in the DLL can be exercised. Per-direction counters let the bench check beat conservation.

## Interface
Parameters:
- PIPE_DATA_WIDTH, 256, beat width; must be a power of two.
- LATENCY, 4, cycles from TX beat to RX beat; legal range 1..16.
- TRAIN_CYCLES, 64, cycles after reset release before the link comes up; legal range 1..1023.

Ports (clock and reset share one clock domain; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_txdata_i  in  PIPE_DATA_WIDTH  endpoint A transmit data.
- a_txvalid_i  in  1  endpoint A transmit beat valid.
- b_rxdata_o  out  PIPE_DATA_WIDTH  data delivered to endpoint B.
- b_rxvalid_o  out  1  delivered beat valid at B.
- b_txdata_i  in  PIPE_DATA_WIDTH  endpoint B transmit data.
- b_txvalid_i  in  1  endpoint B transmit beat valid.
- a_rxdata_o  out  PIPE_DATA_WIDTH  data delivered to endpoint A.
- a_rxvalid_o  out  1  delivered beat valid at A.
- err_inj_i  in  1  single-cycle pulse that arms a bit flip.
- err_dir_i  in  1  direction for the flip: 0 = A→B, 1 = B→A.
- err_bit_i  in  $clog2(PIPE_DATA_WIDTH)  index of the bit to invert.
- link_up_o  out  1  training interval has elapsed.
- ab_fwd_cnt_o, ba_fwd_cnt_o  out  32  beats forwarded, per direction.
- ab_drop_cnt_o, ba_drop_cnt_o  out  16  beats dropped while the link is down.
- ab_err_cnt_o, ba_err_cnt_o  out  16  corrupted beats injected.

## Operation
- Link state machine:
  - TRAIN: counter counts up from 0. Go to UP when the counter reaches TRAIN_CYCLES-1.
  - UP: terminal state. Only rst leaves it.
  - link_up_o is registered. It is 1 exactly in UP.
- Admission: a TX beat with valid=1 enters its pipeline only if link_up_o=1 in that cycle.
  - A valid beat arriving while the link is down is discarded and increments the drop counter.
  - Beats with valid=0 never count.
- Pipeline: each direction is a LATENCY-deep shift register of {valid, data}.
  - It advances every cycle; there is no backpressure.
  - The output stage drives the rx ports directly.
  - When rx valid=0, rx data is forced to all-zeros.
- Error injection:
  - Each direction has an armed flag and a latched bit index.
  - An err_inj_i pulse sets the armed flag for err_dir_i and latches err_bit_i.
  - If that direction is already armed, the pulse is ignored and the earlier index is kept.
  - The next admitted beat in an armed direction has bit [index] inverted at pipeline entry. The same cycle the flag clears and the error counter increments.
  - A pulse in the same cycle as an admitted beat in that direction applies to that beat. The flag never visibly sets.
  - Injection while the link is down stays armed until the first admitted beat.
- Counters:
  - Forward counters increment when a beat is admitted, not when it is delivered.
  - All counters saturate at all-ones and never wrap.
- Both directions are fully independent. Simultaneous A and B traffic, plus an injection into either direction, are all handled in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, including link_up_o, all counters, and both rx valid/data.
- TRAIN_CYCLES timing: with rst deasserted at cycle 0 (first edge with rst=0), link_up_o=1 from cycle TRAIN_CYCLES.
- Latency: a beat admitted at the edge of cycle t appears on rx with valid=1 at cycle t+LATENCY, for exactly one cycle.
- Throughput: one beat per cycle per direction. Back-to-back beats stay back-to-back, and order is preserved.
- Reset mid-operation flushes both pipelines; no in-flight beat emerges. It also clears the armed flags and counters and returns the FSM to TRAIN.

## Test plan
- Reset/training, TRAIN_CYCLES=64: hold a_txvalid_i=1 from reset release → link_up_o rises at cycle 64. ab_drop_cnt_o=64, and no b_rxvalid_o before cycle 64+LATENCY.
- Latency/order, LATENCY=4: after link-up, send 10 back-to-back beats with data=i.
  - b_rxvalid_o is high for cycles t+4..t+13 with data 0..9.
  - ab_fwd_cnt_o=10.
- Bidirectional: simultaneous A→B beat 0xA5 and B→A beat 0x5A → each is delivered 4 cycles later at the opposite end. Both forward counters are 1.
- Error injection:
  - err_inj_i with dir=0, bit=7, then one beat 0x0 → B sees 0x80 and ab_err_cnt_o=1.
  - The following beat 0x0 arrives clean.
  - A second pulse while armed does not double-inject.
- Same-cycle injection: pulse with dir=1, bit=0 in the same cycle as B beat 0x1 → A receives 0x0 and ba_err_cnt_o=1.
- Reset mid-flight: assert rst for 1 cycle while 3 beats are in the pipeline → no rx valid afterwards, all counters are 0, and link_up_o is 0 until TRAIN_CYCLES elapses again.
